cdc_handshake_tx: RTL and testbench

Source-side half of a two-phase (toggle) request/acknowledge handshake that carries a multi-bit word out of the local clock domain. It accepts a word on a valid/ready interface, registers it onto a bus that stays stable, toggles a request line, and waits for the far-side receiver's acknowledge toggle. The acknowledge arrives asynchronously and is resynchronized internally. The block sits in the sending domain, paired with the receiver-side synchronizer that captures `tx_data` on each `tx_req` edge.

---
 rtl/cdc_hs_pkg.sv | 12 +
 rtl/sync_bit.sv | 30 +++
 rtl/cdc_handshake_tx.sv | 104 ++++++++++
 tb/tb_cdc_handshake_tx.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the two-phase (toggle) CDC handshake pair.
// The receiver-side block imports this package as well.
package cdc_hs_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } hs_state_t;

    localparam int CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_bit.sv
// Single-bit resynchronizer: a STAGES-deep flop chain, asynchronously reset to 0.
module sync_bit
    import cdc_hs_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_stages
        $error("sync_bit: STAGES must be at least %0d", CDC_MIN_SYNC_STAGES);
    end

    logic [STAGES-1:0] chain;

    // NOTE: flops use non-blocking assignments so each stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a toggle request/acknowledge handshake carrying one word per transfer.
// Optional acknowledge timeout is enabled with the CDC_TX_TIMEOUT_EN macro.
module cdc_handshake_tx
    import cdc_hs_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_req,
    input  logic                  rx_ack,
    output logic                  busy,
    output logic                  xfer_done,
    output logic                  timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cdc_handshake_tx: TIMEOUT_CYCLES must be at least 1");
    end

    hs_state_t state;
    logic      ack_s;
    logic      ack_match;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_ack),
        .q   (ack_s)
    );

    // The receiver has echoed the current request phase, so the link is free.
    assign ack_match = (ack_s == tx_req);
    assign in_ready  = (state == IDLE) && ack_match;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_req    <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            xfer_done <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        tx_data <= in_data;
                        tx_req  <= ~tx_req;
                        busy    <= 1'b1;
                        state   <= WAIT_ACK;
`ifdef CDC_TX_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                WAIT_ACK: begin
                    // An acknowledge wins over a simultaneous terminal count.
                    if (ack_match) begin
                        busy      <= 1'b0;
                        xfer_done <= 1'b1;
                        state     <= IDLE;
                    end
`ifdef CDC_TX_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        // tx_req keeps its phase so a late acknowledge cannot slip a transfer.
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx with a behavioural toggle receiver.
// Timeout scenario expectations follow the CDC_TX_TIMEOUT_EN macro.
module tb_cdc_handshake_tx;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int TO   = 16;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          rx_ack   = 1'b0;
    logic          in_ready;
    logic [DW-1:0] tx_data;
    logic          tx_req;
    logic          busy;
    logic          xfer_done;
    logic          timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Receiver model state
    bit            rx_enable   = 1'b0;
    int            rx_delay    = 7;
    logic          rx_last_req = 1'b0;
    bit            rx_pending  = 1'b0;
    int            rx_count    = 0;
    int            rx_force_req  = 0;
    int            rx_force_done = 0;
    logic [DW-1:0] rx_q[$];
    int            ack_cyc_q[$];
    logic [DW-1:0] stream[$];

    cdc_handshake_tx #(
        .DATA_WIDTH     (DW),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .rx_ack      (rx_ack),
        .busy        (busy),
        .xfer_done   (xfer_done),
        .timeout_err (timeout_err)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Far-side receiver: captures tx_data on every tx_req edge and echoes the
    // phase on rx_ack rx_delay cycles later; can also be told to toggle once.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_ack      = 1'b0;
                rx_last_req = 1'b0;
                rx_pending  = 1'b0;
            end else begin
                if (rx_pending) begin
                    rx_count--;
                    if (rx_count <= 0) begin
                        rx_ack = ~rx_ack;
                        ack_cyc_q.push_back(cyc);
                        rx_pending = 1'b0;
                    end
                end
                if (rx_force_done < rx_force_req) begin
                    rx_ack = ~rx_ack;
                    ack_cyc_q.push_back(cyc);
                    rx_force_done++;
                end
                if (tx_req !== rx_last_req) begin
                    rx_last_req = tx_req;
                    rx_q.push_back(tx_data);
                    if (rx_enable) begin
                        rx_pending = 1'b1;
                        rx_count   = rx_delay;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_queues();
        rx_q.delete();
        ack_cyc_q.delete();
    endtask

    task automatic wait_done(input int budget, input logic [DW-1:0] hold, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (xfer_done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            tests_run++;
            if (tx_data !== hold) begin
                tests_failed++;
                $display("FAIL hold_tx_data: got %h, expected %h", tx_data, hold);
            end
            tick();
        end
        tests_run++;
        if (done_cyc < 0) begin
            tests_failed++;
            $display("FAIL done_wait: no xfer_done within %0d cycles, expected one", budget);
        end
    endtask

    task automatic check_rx_order(input string name);
        tests_run++;
        if (rx_q.size() != stream.size()) begin
            tests_failed++;
            $display("FAIL %s_count: receiver got %0d words, expected %0d", name, rx_q.size(), stream.size());
        end else begin
            for (int i = 0; i < stream.size(); i++) begin
                tests_run++;
                if (rx_q[i] !== stream[i]) begin
                    tests_failed++;
                    $display("FAIL %s_word%0d: got %h, expected %h", name, i, rx_q[i], stream[i]);
                end
            end
        end
    endtask

    // Offers every word of stream in order (optionally with idle gaps) and
    // checks completion latency relative to the receiver's acknowledge.
    task automatic run_stream(input bit rand_gaps, output int dones, output int toggles);
        int   idx   = 0;
        int   guard = 0;
        int   a;
        bit   hs;
        logic prev_req;
        dones    = 0;
        toggles  = 0;
        prev_req = tx_req;
        while (dones < stream.size() && guard < 2000) begin
            if (idx < stream.size() && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = stream[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end
            if (rand_gaps) rx_delay = $urandom_range(1, 8);
            hs = in_valid && in_ready;
            if (xfer_done === 1'b1) begin
                dones++;
                tests_run++;
                if (in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL ready_on_done: in_ready=%b, expected 1", in_ready);
                end
                tests_run++;
                if (ack_cyc_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL done_without_ack: xfer_done at cycle %0d, expected none", cyc);
                end else begin
                    a = ack_cyc_q.pop_front();
                    if (cyc - a != SYNC + 1) begin
                        tests_failed++;
                        $display("FAIL ack_latency: got %0d cycles, expected %0d", cyc - a, SYNC + 1);
                    end
                end
            end
            if (busy === 1'b1 && idx > 0) begin
                tests_run++;
                if (tx_data !== stream[idx-1]) begin
                    tests_failed++;
                    $display("FAIL stream_hold: tx_data=%h, expected %h", tx_data, stream[idx-1]);
                end
            end
            tick();
            guard++;
            if (tx_req !== prev_req) toggles++;
            prev_req = tx_req;
            if (hs) idx++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (guard >= 2000) begin
            tests_failed++;
            $display("FAIL stream_stall: %0d of %0d transfers done, expected all", dones, stream.size());
        end
    endtask

    task automatic test_reset();
        int dc;
        clear_queues();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        rx_enable = 1'b1;
        rx_delay  = 3;
        repeat (3) tick();
        tests_run++;
        if ({tx_data, tx_req, busy, xfer_done, timeout_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: tx_data=%h tx_req=%b busy=%b done=%b terr=%b, expected all 0",
                     tx_data, tx_req, busy, xfer_done, timeout_err);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_idle: in_ready=%b, expected 1", in_ready);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_ready: in_ready=%b, expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (tx_req !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_accept: tx_req=%b tx_data=%h busy=%b, expected 1 a5 1", tx_req, tx_data, busy);
        end
        wait_done(40, 8'hA5, dc);
        tick();
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL first_capture: receiver got %0d words, expected one a5", rx_q.size());
        end
    endtask

    task automatic test_single();
        int   a;
        int   dc;
        logic req0;
        clear_queues();
        rx_enable = 1'b1;
        rx_delay  = 7;
        req0      = tx_req;
        in_data   = 8'h3C;
        in_valid  = 1'b1;
        tick();
        a        = cyc;
        in_valid = 1'b0;
        tests_run++;
        if (tx_req !== ~req0 || tx_data !== 8'h3C || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_accept: tx_req=%b tx_data=%h busy=%b, expected %b 3c 1", tx_req, tx_data, busy, ~req0);
        end
        wait_done(40, 8'h3C, dc);
        tests_run++;
        if (dc != a + 7 + SYNC + 1) begin
            tests_failed++;
            $display("FAIL single_latency: done at cycle %0d, expected %0d", dc, a + 7 + SYNC + 1);
        end
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_idle: busy=%b in_ready=%b, expected 0 1", busy, in_ready);
        end
        tick();
        tests_run++;
        if (xfer_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pulse: xfer_done=%b one cycle later, expected 0", xfer_done);
        end
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
            tests_failed++;
            $display("FAIL single_capture: receiver got %0d words, expected one 3c", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        int toggles;
        clear_queues();
        rx_enable = 1'b1;
        rx_delay  = 1;
        stream    = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_stream(1'b0, dones, toggles);
        tests_run++;
        if (toggles != 4 || dones != 4) begin
            tests_failed++;
            $display("FAIL b2b_counts: toggles=%0d dones=%0d, expected 4 4", toggles, dones);
        end
        check_rx_order("b2b");
    endtask

    task automatic test_hold();
        int   guard = 0;
        logic req1;
        clear_queues();
        rx_enable = 1'b1;
        rx_delay  = 10;
        in_data   = 8'h5A;
        in_valid  = 1'b1;
        tick();
        req1    = tx_req;
        in_data = 8'hFF;
        while (xfer_done !== 1'b1 && guard < 60) begin
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_ready: in_ready=%b during wait, expected 0", in_ready);
            end
            tests_run++;
            if (tx_data !== 8'h5A) begin
                tests_failed++;
                $display("FAIL hold_data: tx_data=%h during wait, expected 5a", tx_data);
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (guard >= 60) begin
            tests_failed++;
            $display("FAIL hold_done: no xfer_done within 60 cycles, expected one");
        end
        tick();
        tests_run++;
        if (tx_data !== 8'h5A || tx_req !== req1 || rx_q.size() != 1) begin
            tests_failed++;
            $display("FAIL hold_ignored: tx_data=%h tx_req=%b words=%0d, expected 5a %b 1",
                     tx_data, tx_req, rx_q.size(), req1);
        end
    endtask

    task automatic test_timeout();
        int a;
        int t;
`ifdef CDC_TX_TIMEOUT_EN
        int pulses    = 0;
        int pulse_cyc = -1;
`else
        int dc;
`endif
        clear_queues();
        rx_enable = 1'b0;
        in_data   = 8'hC3;
        in_valid  = 1'b1;
        tick();
        a        = cyc;
        in_valid = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        for (int k = 1; k <= TO + 4; k++) begin
            tick();
            if (timeout_err === 1'b1) begin
                pulses++;
                pulse_cyc = cyc;
            end
            tests_run++;
            if (in_ready !== 1'b0 || xfer_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_wait: in_ready=%b xfer_done=%b, expected 0 0", in_ready, xfer_done);
            end
        end
        tests_run++;
        if (pulses != 1 || pulse_cyc != a + TO) begin
            tests_failed++;
            $display("FAIL timeout_pulse: %0d pulses at cycle %0d, expected 1 at %0d", pulses, pulse_cyc, a + TO);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_busy: busy=%b, expected 0", busy);
        end
        #1 rx_force_req++;
        tick();
        t = cyc;
        tick();
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_ack_early: in_ready=%b at %0d edge, expected 0", in_ready, cyc - t);
        end
        tick();
        tests_run++;
        if (in_ready !== 1'b1 || xfer_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_ack_ready: in_ready=%b xfer_done=%b after %0d edges, expected 1 0",
                     in_ready, xfer_done, cyc - t);
        end
`else
        for (int k = 1; k <= 40; k++) begin
            tick();
            tests_run++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || timeout_err !== 1'b0 || xfer_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL no_ack_wait: busy=%b in_ready=%b terr=%b done=%b, expected 1 0 0 0",
                         busy, in_ready, timeout_err, xfer_done);
            end
        end
        #1 rx_force_req++;
        tick();
        t = cyc;
        wait_done(10, 8'hC3, dc);
        tests_run++;
        if (dc != t + SYNC + 1) begin
            tests_failed++;
            $display("FAIL late_ack_done: done at cycle %0d, expected %0d", dc, t + SYNC + 1);
        end
        tick();
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_ack_idle: in_ready=%b busy=%b, expected 1 0", in_ready, busy);
        end
`endif
        rx_enable = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        clear_queues();
        rx_enable = 1'b1;
        rx_delay  = 10;
        in_data   = 8'h77;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (tx_req !== 1'b0 || busy !== 1'b0 || tx_data !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: tx_req=%b busy=%b tx_data=%h, expected 0 0 00", tx_req, busy, tx_data);
        end
        tick();
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_ready: in_ready=%b, expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_random();
        int dones;
        int toggles;
        clear_queues();
        rx_enable = 1'b1;
        stream.delete();
        for (int i = 0; i < 24; i++) stream.push_back(DW'($urandom));
        run_stream(1'b1, dones, toggles);
        tests_run++;
        if (toggles != 24 || dones != 24) begin
            tests_failed++;
            $display("FAIL rand_counts: toggles=%0d dones=%0d, expected 24 24", toggles, dones);
        end
        check_rx_order("rand");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
